// File: rtl/imem_loader.sv
// Length-prefixed byte-stream loader for the CPU instruction memory; holds the CPU in reset until the load completes.
// Optional trailing XOR checksum byte is enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned WORD_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              byte_valid_i,
  input  logic [7:0]        byte_data_i,
  output logic              byte_ready_o,
  output logic              imem_we_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  output logic [WORD_W-1:0] imem_data_o,
  output logic              cpu_rst_n_o,
  output logic              cpu_start_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_HDR_HI = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_CHECK  = 3'd3;
  localparam logic [2:0] S_FINISH = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;
  localparam logic [2:0] S_ERR    = 3'd6;

  logic [2:0]        state_q, state_d;
  logic [7:0]        nlo_q, nlo_d;
  logic [ADDR_W:0]   n_q, n_d;
  logic [ADDR_W:0]   idx_q, idx_d;
  logic [1:0]        lane_q, lane_d;
  logic [23:0]       shift_q, shift_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [WORD_W-1:0] data_q, data_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]        csum_q, csum_d;
`endif

  logic        accept;
  logic        last_pending;
  logic [15:0] n_full;

  assign n_full = {byte_data_i, nlo_q};

  // Final word is being written this cycle: stay in DATA without taking bytes so FINISH follows the write.
  assign last_pending = (state_q == S_DATA) && we_q && (idx_q == n_q);

  always_comb begin
    byte_ready_o = 1'b0;
    case (state_q)
      S_IDLE, S_HDR_HI, S_CHECK: byte_ready_o = 1'b1;
      S_DATA:                    byte_ready_o = !last_pending;
      default:                   byte_ready_o = 1'b0;
    endcase
  end

  assign accept = byte_valid_i && byte_ready_o;

  always_comb begin
    state_d = state_q;
    nlo_d   = nlo_q;
    n_d     = n_q;
    idx_d   = idx_q;
    lane_d  = lane_q;
    shift_d = shift_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    csum_d  = csum_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          nlo_d   = byte_data_i;
          state_d = S_HDR_HI;
        end
      end
      S_HDR_HI: begin
        if (accept) begin
          if ((n_full == '0) || (n_full > 16'(2**ADDR_W))) begin
            state_d = S_ERR;
          end else begin
            n_d     = n_full[ADDR_W:0];
            idx_d   = '0;
            lane_d  = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_d  = '0;
`endif
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (last_pending) begin
          state_d = S_FINISH;
        end else if (accept) begin
          lane_d = lane_q + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum_d = csum_q ^ byte_data_i;
`endif
          if (lane_q == 2'd3) begin
            we_d   = 1'b1;
            addr_d = idx_q[ADDR_W-1:0];
            data_d = {byte_data_i, shift_q};
            idx_d  = idx_q + 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            if ((idx_q + 1'b1) == n_q) state_d = S_CHECK;
`endif
          end else begin
            shift_d = {byte_data_i, shift_q[23:8]};
          end
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CHECK: begin
        if (accept) state_d = (byte_data_i == csum_q) ? S_FINISH : S_ERR;
      end
`endif
      S_FINISH: state_d = S_DONE;
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      nlo_q   <= '0;
      n_q     <= '0;
      idx_q   <= '0;
      lane_q  <= '0;
      shift_q <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      nlo_q   <= nlo_d;
      n_q     <= n_d;
      idx_q   <= idx_d;
      lane_q  <= lane_d;
      shift_q <= shift_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

  assign imem_we_o   = we_q;
  assign imem_addr_o = addr_q;
  assign imem_data_o = data_q;
  assign cpu_rst_n_o = (state_q == S_DONE);
  assign cpu_start_o = (state_q == S_DONE);
  assign done_o      = (state_q == S_DONE);
  assign err_o       = (state_q == S_ERR);
  assign busy_o      = (state_q != S_IDLE) && (state_q != S_DONE) && (state_q != S_ERR);

endmodule
